cgra_addr_seq: RTL and testbench
================================

// Module: cgra_addr_seq
// PURPOSE
// Address sequencer upstream of the CGRA data-BRAM ports. Each CGRA cycle it reads one
// control word from the address-control BRAM. It decodes the word into a read, write or
// bubble access on the data BRAM port, so the Torus PE array gets load data and store
// slots in the compiled schedule order. It implements the Computation_Start/Done handshake
// for one kernel run.
// PARAMETERS
// DWIDTH    32  control-word / data width
// AW        16  BRAM word-address width (Ctrl_Addr, Mem_Addr)
// CNT_W     16  schedule-length counter width
// BYTE_LEN  4   byte-write-enable width
// PORTS
// Clk        in   1        system clock (all logic on rising edge)
// Rst        in   1        reset, asynchronous, active-high
// Start      in   1        Computation_Start level from software
// Length     in   CNT_W    number of schedule entries; sampled on start edge
// Done       out  1        Computation_Done
// Busy       out  1        PE_Array_Busy: high from start edge until last access issued
// Ctrl_En    out  1        address-control BRAM read enable
// Ctrl_Addr  out  AW       address-control BRAM word address
// Ctrl_Data  in   DWIDTH   control word; valid 1 cycle after Ctrl_En (BRAM latency 1)
// Mem_En     out  1        data BRAM enable
// Mem_Wen    out  BYTE_LEN data BRAM byte write enable (all-1 or all-0)
// Mem_Addr   out  AW       data BRAM word address
// Step       out  CNT_W    index of the entry currently on Mem_*
// BEHAVIOUR
// Control word: [31] valid, [30] write, [AW-1:0] address; other bits ignored.
// Reset (async): state IDLE; every output 0; Start_q=0.
// FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
// IDLE: Start=1 && Start_q=0 (rising edge) latches Length into Len_r.
//   Len_r=0: go to DONE; no Ctrl or Mem access. Else: go to RUN, Busy=1, Ctrl_Addr=0.
//   Start held high with no edge: stay in IDLE.
// RUN: Ctrl_En=1; Ctrl_Addr advances by 1 each cycle for entries 0..Len_r-1.
//   Fetch counter reaches Len_r-1: Ctrl_En drops next cycle; state -> DRAIN.
// Decode is registered. Ctrl_Data for entry k arrives in cycle t+1.
//   Mem_* for entry k are valid in cycle t+2 (2-cycle fetch-to-access latency).
//   Mem_En = valid; Mem_Wen = {BYTE_LEN{valid & write}}; Mem_Addr = addr; Step = k.
//   valid=0 is a bubble: Mem_En=0, Mem_Wen=0, Mem_Addr holds its previous value.
// DRAIN: lasts 2 cycles so the last entry reaches Mem_*. Then Mem_En=0, Mem_Wen=0,
//   Busy=0, state -> DONE.
// DONE: Done=1 until Start is sampled low, then -> IDLE and Done=0 next cycle.
//   If Start is already low on entry, Done is high for exactly 1 cycle.
// Start falling during RUN/DRAIN: ignored; the run completes.
// Step wraps modulo 2^CNT_W. Ctrl_Addr is the low AW bits of the fetch counter.
//   Len_r > 2^AW wraps the control address; software must not request this.
// Reset mid-run: aborts at once; no further Mem access; next run needs a fresh Start edge.
// CONFIGURATION
// CGRA_ADDR_SEQ_PERF_EN defined: adds output Perf_Cycles [31:0].
//   Counts cycles with Busy=1; cleared on start edge; saturates at 32'hFFFF_FFFF;
//   holds its value after the run.
//   Reset value 0.
// Not defined: port and counter absent; all other behaviour identical.
// TESTING
// 1 Length=4, words {V|R|0x10, V|W|0x11, bubble, V|R|0x13}, Start edge at cycle 0:
//   Mem_En 1,1,0,1; Mem_Wen 0,F,0,0; Mem_Addr 0x10,0x11,0x11,0x13; Step 0..3.
//   Accesses in cycles 3..6.
// 2 Length=0, Start edge: Done=1 next cycle; Ctrl_En and Mem_En never assert;
//   Busy stays 0.
// 3 Start held high through DONE: Done stays 1; Start drops -> Done=0 a cycle later;
//   re-raising Start starts a new run with Ctrl_Addr=0.
// 4 Length=8: assert Rst at entry 3. All outputs 0 asynchronously.
//   After Rst release, Start held high gives no run until low-then-high.
// 5 Length=1, word V|W|0x7FF: single write (Mem_Wen=F, Mem_Addr=0x7FF).
//   Busy falls at the end of DRAIN.
// 6 PERF_EN build, Length=5: Perf_Cycles = number of Busy-high cycles, checked
//   against the bench count. Non-PERF build: same Mem_* trace, port absent.

Source files
------------

// File: rtl/cgra_addr_seq.sv
// Address sequencer: fetches one control word per cycle and turns it into a data-BRAM access.
// Optional macro CGRA_ADDR_SEQ_PERF_EN adds the Perf_Cycles busy-cycle counter output.
module cgra_addr_seq #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned AW       = 16,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned BYTE_LEN = 4
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic [CNT_W-1:0]    Length,
  output logic                Done,
  output logic                Busy,
  output logic                Ctrl_En,
  output logic [AW-1:0]       Ctrl_Addr,
  input  logic [DWIDTH-1:0]   Ctrl_Data,
  output logic                Mem_En,
  output logic [BYTE_LEN-1:0] Mem_Wen,
  output logic [AW-1:0]       Mem_Addr,
  output logic [CNT_W-1:0]    Step
`ifdef CGRA_ADDR_SEQ_PERF_EN
  ,
  output logic [31:0]         Perf_Cycles
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic               start_q;
  logic               armed;
  logic               start_edge;
  logic [CNT_W-1:0]   len_r;
  logic [CNT_W-1:0]   fcnt;
  logic               last_fetch;
  logic               drain_cnt;
  logic               rd_v;
  logic [CNT_W-1:0]   rd_step;
  logic               w_valid;
  logic               w_write;
  logic               unused_bits;

  // armed stays low after reset until Start is seen low, so a level held through reset cannot launch a run
  assign start_edge = Start & ~start_q & armed;
  assign last_fetch = (fcnt == len_r - CNT_W'(1));
  assign w_valid    = Ctrl_Data[DWIDTH-1];
  assign w_write    = Ctrl_Data[DWIDTH-2];
  assign unused_bits = ^Ctrl_Data[DWIDTH-3:AW];

  assign Busy      = (state == RUN) || (state == DRAIN);
  assign Ctrl_En   = (state == RUN);
  assign Done      = (state == DONE);
  assign Ctrl_Addr = AW'(fcnt);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start_edge) state_nxt = (Length == '0) ? DONE : RUN;
      RUN:   if (last_fetch) state_nxt = DRAIN;
      DRAIN: if (drain_cnt)  state_nxt = DONE;
      DONE:  if (!Start)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      start_q   <= 1'b0;
      armed     <= 1'b0;
      len_r     <= '0;
      fcnt      <= '0;
      drain_cnt <= 1'b0;
      rd_v      <= 1'b0;
      rd_step   <= '0;
    end else begin
      start_q   <= Start;
      if (!Start) armed <= 1'b1;
      if (state == IDLE && start_edge) begin
        len_r <= Length;
        fcnt  <= '0;
      end else if (state == RUN && !last_fetch) begin
        fcnt <= fcnt + CNT_W'(1);
      end
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      rd_v      <= Ctrl_En;
      rd_step   <= fcnt;
    end
  end

  // Second pipeline stage: the word read last cycle becomes the access; bubbles keep the old address
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Mem_En   <= 1'b0;
      Mem_Wen  <= '0;
      Mem_Addr <= '0;
      Step     <= '0;
    end else if (rd_v) begin
      Mem_En  <= w_valid;
      Mem_Wen <= (w_valid && w_write) ? '1 : '0;
      if (w_valid) Mem_Addr <= Ctrl_Data[AW-1:0];
      Step    <= rd_step;
    end else begin
      Mem_En  <= 1'b0;
      Mem_Wen <= '0;
    end
  end

`ifdef CGRA_ADDR_SEQ_PERF_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                                  Perf_Cycles <= '0;
    else if (state == IDLE && start_edge)     Perf_Cycles <= '0;
    else if (Busy && (Perf_Cycles != '1))     Perf_Cycles <= Perf_Cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cgra_addr_seq.sv
// Scoreboard bench for cgra_addr_seq: expected accesses are queued when a run is launched
// and popped as the Mem_* port produces them.
module tb_cgra_addr_seq;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [15:0] Length;
  logic        Done;
  logic        Busy;
  logic        Ctrl_En;
  logic [15:0] Ctrl_Addr;
  logic [31:0] Ctrl_Data = '0;
  logic        Mem_En;
  logic [3:0]  Mem_Wen;
  logic [15:0] Mem_Addr;
  logic [15:0] Step;
`ifdef CGRA_ADDR_SEQ_PERF_EN
  logic [31:0] Perf_Cycles;
`endif

  cgra_addr_seq #(.DWIDTH(32), .AW(16), .CNT_W(16), .BYTE_LEN(4)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Length(Length), .Done(Done), .Busy(Busy),
    .Ctrl_En(Ctrl_En), .Ctrl_Addr(Ctrl_Addr), .Ctrl_Data(Ctrl_Data),
    .Mem_En(Mem_En), .Mem_Wen(Mem_Wen), .Mem_Addr(Mem_Addr), .Step(Step)
`ifdef CGRA_ADDR_SEQ_PERF_EN
    , .Perf_Cycles(Perf_Cycles)
`endif
  );

  always #5 Clk = ~Clk;

  logic [31:0] ctrl_mem [0:255];
  always @(posedge Clk) if (Ctrl_En) Ctrl_Data <= ctrl_mem[Ctrl_Addr[7:0]];

  typedef struct packed {
    logic        en;
    logic [3:0]  wen;
    logic [15:0] addr;
    logic [15:0] step;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] last_addr;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_words(input int unsigned len);
    exp_t e;
    logic [31:0] w;
    for (int unsigned k = 0; k < len; k++) begin
      w = ctrl_mem[k];
      if (w[31]) last_addr = w[15:0];
      e.en   = w[31];
      e.wen  = (w[31] && w[30]) ? 4'hF : 4'h0;
      e.addr = last_addr;
      e.step = 16'(k);
      sb.push_back(e);
    end
  endtask

  // c = cycles after the clock edge that sampled the Start rising edge
  task automatic cycle_checks(input int unsigned c, input int unsigned len);
    int unsigned done_c;
    exp_t e;
    done_c = (len == 0) ? 1 : len + 3;
    check("busy", Busy, (len != 0) && (c <= len + 2));
    check("ctrl_en", Ctrl_En, c <= len);
    if (c <= len) check("ctrl_addr", Ctrl_Addr, c - 1);
    check("done", Done, c == done_c);
    if (len != 0 && c >= 3 && c <= len + 2) begin
      if (sb.size() == 0) check("sb_underflow", 0, 1);
      else begin
        e = sb.pop_front();
        check("mem_en", Mem_En, e.en);
        check("mem_wen", Mem_Wen, e.wen);
        check("mem_addr", Mem_Addr, e.addr);
        check("step", Step, e.step);
      end
    end else begin
      check("mem_en_idle", Mem_En, 0);
      check("mem_wen_idle", Mem_Wen, 0);
    end
  endtask

  task automatic run(input int unsigned len, input bit drop);
    int unsigned done_c;
    done_c = (len == 0) ? 1 : len + 3;
    push_words(len);
    Length = 16'(len);
    Start  = 1'b1;
    for (int unsigned c = 1; c <= done_c; c++) begin
      @(negedge Clk);
      cycle_checks(c, len);
      if (c == 1 && drop) Start = 1'b0;
    end
`ifdef CGRA_ADDR_SEQ_PERF_EN
    check("perf_cycles", Perf_Cycles, (len == 0) ? 0 : len + 2);
`endif
    if (drop) begin
      @(negedge Clk);
      check("done_fall", Done, 0);
      check("busy_after", Busy, 0);
      check("sb_drained", sb.size(), 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, Done, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_ctrl_en"}, Ctrl_En, 0);
    check({tag, "_ctrl_addr"}, Ctrl_Addr, 0);
    check({tag, "_mem_en"}, Mem_En, 0);
    check({tag, "_mem_wen"}, Mem_Wen, 0);
    check({tag, "_mem_addr"}, Mem_Addr, 0);
    check({tag, "_step"}, Step, 0);
`ifdef CGRA_ADDR_SEQ_PERF_EN
    check({tag, "_perf"}, Perf_Cycles, 0);
`endif
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Length = '0; last_addr = '0;
    for (int i = 0; i < 256; i++) ctrl_mem[i] = '0;
    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    Rst = 1'b0;
    repeat (2) @(negedge Clk);

    // 1: read, write, bubble, read
    ctrl_mem[0] = 32'h8000_0010; ctrl_mem[1] = 32'hC000_0011;
    ctrl_mem[2] = 32'h4000_0099; ctrl_mem[3] = 32'h8000_0013;
    run(4, 1'b1);
    repeat (2) @(negedge Clk);

    // 2: zero length
    run(0, 1'b1);
    repeat (2) @(negedge Clk);

    // 3: Start held through DONE, then dropped, then a fresh run
    ctrl_mem[0] = 32'hC000_0200; ctrl_mem[1] = 32'h8000_0201; ctrl_mem[2] = 32'h0000_0000;
    run(3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("done_hold", Done, 1);
      check("busy_hold", Busy, 0);
    end
    Start = 1'b0;
    @(negedge Clk);
    check("done_release", Done, 0);
    ctrl_mem[0] = 32'h8000_0300; ctrl_mem[1] = 32'hC000_0301;
    run(2, 1'b1);
    repeat (2) @(negedge Clk);

    // 5: single write
    ctrl_mem[0] = 32'hC000_07FF;
    run(1, 1'b1);
    repeat (2) @(negedge Clk);

    // 6: random words
    for (int k = 0; k < 5; k++) ctrl_mem[k] = {$urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, 14'($urandom), 16'($urandom)};
    ctrl_mem[0][31] = 1'b1;
    run(5, 1'b1);
    repeat (2) @(negedge Clk);

    // 4: async reset mid-run
    for (int k = 0; k < 8; k++) ctrl_mem[k] = 32'h8000_0100 + 32'(k);
    push_words(8);
    Length = 16'd8;
    Start  = 1'b1;
    for (int unsigned c = 1; c <= 6; c++) begin
      @(negedge Clk);
      cycle_checks(c, 8);
    end
    #2 Rst = 1'b1;
    #1 check_all_zero("async_rst");
    sb.delete();
    last_addr = '0;
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("no_run_busy", Busy, 0);
      check("no_run_ctrl_en", Ctrl_En, 0);
      check("no_run_done", Done, 0);
    end
    Start = 1'b0;
    @(negedge Clk);
    ctrl_mem[0] = 32'hC000_0AAA; ctrl_mem[1] = 32'h8000_0BBB;
    run(2, 1'b1);

    repeat (2) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
